uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
UART transmit path, the counterpart of the Rx sampling chain. It accepts a parallel byte over a valid/ready handshake and serializes it LSB-first on the tx line. The frame is one start bit, DATA_BITS data bits, an optional parity bit, then STOP_BITS stop bits. Each bit is held for exactly CLOCKS_PER_BIT system clocks, using the same bit timing as the receiver (48 MHz system clock, 9600 baud, 5000 clocks per bit).

Parameters:
CLOCKS_PER_BIT, 5000, system clocks per UART bit; minimum legal value 2
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY_MODE, 0, parity bit: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
tx_data  input  DATA_BITS  byte to send; sampled only on handshake
tx_valid  input  1  upstream has a byte on tx_data
tx_ready  output  1  block can accept a byte this cycle
tx  output  1  serial line, registered, idle level 1
tx_busy  output  1  high while a frame is on the line (start bit through last stop bit)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: tx=1, tx_ready=1, tx_busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- Handshake: a byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register on that edge.
  - Parity is computed from the latched value on that edge.
  - tx_valid while tx_ready=0 is ignored and is not queued.
  - tx_data changes after acceptance have no effect.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY_MODE != 0) -> STOP -> IDLE.
  - IDLE: tx=1, tx_ready=1, tx_busy=0. Goes to START on handshake.
  - START: tx=0 from the cycle after acceptance.
  - DATA: tx = shift_reg[0]. Shift right on each bit tick. After DATA_BITS ticks, go to PARITY or STOP.
  - PARITY: tx = parity bit. Odd mode: XOR of the data bits, inverted. Even mode: XOR of the data bits.
  - STOP: tx=1 for STOP_BITS bit periods, then go to IDLE.
  - tx_ready=0 and tx_busy=1 in every state except IDLE.
- Baud counter:
  - Cleared to 0 on acceptance.
  - Increments every cycle outside IDLE.
  - Issues a bit tick and wraps to 0 when it equals CLOCKS_PER_BIT-1.
  - Width is clog2(CLOCKS_PER_BIT); no overflow is possible.
  - Every bit, including start and stop, lasts exactly CLOCKS_PER_BIT cycles.
- Latency and timing:
  - The tx falling edge occurs on the cycle after acceptance.
  - Frame length F = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * CLOCKS_PER_BIT cycles.
  - tx_ready returns to 1 on the first cycle after the final stop-bit cycle.
  - With tx_valid held high, the minimum start-to-start spacing is F + 1 cycles.
- The tx output is glitch-free: it is driven directly from a flop, never combinationally.
- Reset mid-frame takes effect on the next edge: tx=1, state=IDLE, the frame is truncated and the in-flight byte is dropped.
- Reset together with tx_valid: reset wins and no byte is accepted.

Decomposition:
- Shared package uart_pkg holds:
  - Constants CLOCKS_PER_BIT, DATA_BITS, PARITY_MODE and STOP_BITS, shared with the Rx path.
  - The PARITY_NONE/ODD/EVEN encodings.
  - The tx state enum IDLE/START/DATA/PARITY/STOP.
- One sub-module, uart_tx_baud_tick: a baud counter with clear and enable inputs and a one-cycle bit_tick output.
- The FSM, shift register and parity logic stay in the top module.

Test Plan:
1. CLOCKS_PER_BIT=16, 8N1, send 0xA5 -> tx low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles. tx_ready is low for exactly 160 cycles.
2. tx_valid held high with 0x00 then 0xFF -> second start bit falls exactly 161 cycles after the first. Both bytes decode correctly.
3. PARITY_MODE=2 with 0x07, then PARITY_MODE=1 with 0x07 -> parity bit 1 for even, 0 for odd. Frame is 176 cycles.
4. STOP_BITS=2, send 0x3C -> stop level held 32 cycles. tx_ready rises on cycle 177 after acceptance.
5. Reset asserted 50 cycles into a frame -> next cycle tx=1, tx_ready=1, tx_busy=0. A following 0x5A transmits cleanly.
6. tx_valid pulsed with 0x11 mid-frame, then tx_data changed -> pulse ignored and the current frame bits are unchanged. Run against the Rx path in loopback at CLOCKS_PER_BIT=5000 and check 0x55 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, parity encodings and Tx state type.
// The Tx and Rx paths both use these defaults, so their bit timing stays aligned.
package uart_pkg;

  // 48 MHz system clock at 9600 baud
  localparam int CLOCKS_PER_BIT = 5000;
  localparam int DATA_BITS      = 8;
  localparam int PARITY_MODE    = 0;
  localparam int STOP_BITS      = 1;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period timer. It counts while enabled and issues a one-cycle tick on the
// last cycle of each bit period. clr_i restarts the period from zero.
module uart_tx_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_tick_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, then wrap at the end of the bit period
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bit_tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter. It accepts a byte over a valid/ready handshake and sends it
// LSB-first in this frame order: start bit, data bits, optional parity bit, stop bits.
// tx is taken straight from a flop. Its next value is decoded from the next state,
// so the start bit falls on the cycle right after acceptance.
module uart_tx_serializer #(
  parameter int CLOCKS_PER_BIT = uart_pkg::CLOCKS_PER_BIT,
  parameter int DATA_BITS      = uart_pkg::DATA_BITS,
  parameter int PARITY_MODE    = uart_pkg::PARITY_MODE,
  parameter int STOP_BITS      = uart_pkg::STOP_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  import uart_pkg::tx_state_e;
  import uart_pkg::IDLE;
  import uart_pkg::START;
  import uart_pkg::DATA;
  import uart_pkg::PARITY;
  import uart_pkg::STOP;
  import uart_pkg::PARITY_NONE;
  import uart_pkg::PARITY_ODD;

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 accept;
  logic                 bit_tick;

  // A byte is only accepted while the line is idle; valid at other times is dropped
  assign accept = tx_valid && (state_q == IDLE);

  uart_tx_baud_tick #(
    .CLKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (accept),
    .en_i      (state_q != IDLE),
    .bit_tick_o(bit_tick)
  );

  // Frame sequencing, data shifting, parity capture and next line level
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
          parity_d  = (PARITY_MODE == PARITY_ODD) ? ~^tx_data : ^tx_data;
        end
      end
      START: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_d = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level for the cycle after this edge
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset drops any in-flight frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer. Several configurations share one clock.
// Expected frame bits are pushed to a queue when a byte is offered to a DUT, then
// popped and compared as each bit appears on that DUT's tx line.
module tb_uart_tx_serializer;

  localparam int NI = 5;

  logic            clk = 1'b0;
  logic [NI-1:0]   rst;
  logic [NI-1:0]   vld;
  logic [7:0]      dat [NI];
  wire  [NI-1:0]   txl, rdy, busy;

  int ncmp  = 0;
  int nfail = 0;
  int cyc   = 0;
  logic exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: 8N1 cpb16 | 1: 8E1 | 2: 8O1 | 3: 8N2 | 4: 8N1 at the real 5000-clock rate
  uart_tx_serializer #(.CLOCKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(rst[0]), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]));
  uart_tx_serializer #(.CLOCKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(rst[1]), .tx_data(dat[1]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]));
  uart_tx_serializer #(.CLOCKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(rst[2]), .tx_data(dat[2]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]));
  uart_tx_serializer #(.CLOCKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(rst[3]), .tx_data(dat[3]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(busy[3]));
  uart_tx_serializer #(.CLOCKS_PER_BIT(5000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u4 (
    .clk(clk), .reset(rst[4]), .tx_data(dat[4]), .tx_valid(vld[4]),
    .tx_ready(rdy[4]), .tx(txl[4]), .tx_busy(busy[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, data LSB-first, parity (1=odd, 2=even), stop bits
  task automatic push_frame(input logic [7:0] d, input int pm, input int sb);
    logic p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pm == 1) exp_q.push_back(~p);
    if (pm == 2) exp_q.push_back(p);
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endtask

  // Offer a byte at a negedge; the following posedge accepts it
  task automatic offer(input int k, input logic [7:0] d);
    @(negedge clk);
    chk($sformatf("u%0d ready before offer", k), 32'(rdy[k]), 32'd1);
    vld[k] = 1'b1;
    dat[k] = d;
  endtask

  // Walk one frame. Cycle c=1 is the first negedge after acceptance.
  // full=1 checks the first and last cycle of every bit; full=0 samples each bit
  // at its middle, as a receiver would. pulse_at>0 drives a stray valid pulse mid-frame.
  task automatic run_frame(input int k, input int cpb, input int nbits, input bit hold,
                           input logic [7:0] nxt, input int pulse_at, input bit full,
                           output int t_start);
    logic cur;
    int   nlow;
    int   j;
    cur = 1'b1;
    nlow = 0;
    t_start = 0;
    for (int c = 1; c <= nbits * cpb; c++) begin
      @(negedge clk);
      if (c == 1) begin
        vld[k] = hold;
        dat[k] = nxt;
        t_start = cyc;
      end
      if (pulse_at > 0 && c == pulse_at) begin
        vld[k] = 1'b1;
        dat[k] = 8'h11;
      end
      if (pulse_at > 0 && c == pulse_at + 1) begin
        vld[k] = 1'b0;
        dat[k] = 8'hEE;
      end
      j = (c - 1) / cpb;
      if ((c - 1) % cpb == 0) begin
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL u%0d scoreboard empty at bit %0d: got nothing want a bit", k, j);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (full && ((c - 1) % cpb == 0 || (c - 1) % cpb == cpb - 1))
        chk($sformatf("u%0d bit%0d edge c%0d", k, j, c), 32'(txl[k]), 32'(cur));
      if (!full && (c - 1) % cpb == cpb / 2)
        chk($sformatf("u%0d bit%0d mid", k, j), 32'(txl[k]), 32'(cur));
      if (rdy[k] == 1'b0) nlow++;
    end
    chk($sformatf("u%0d ready-low cycles", k), 32'(nlow), 32'(nbits * cpb));
    @(negedge clk);
    chk($sformatf("u%0d ready after frame", k), 32'(rdy[k]), 32'd1);
    chk($sformatf("u%0d busy after frame", k), 32'(busy[k]), 32'd0);
    chk($sformatf("u%0d tx idle after frame", k), 32'(txl[k]), 32'd1);
  endtask

  initial begin
    int t0, t1;
    rst = '1;
    vld = '0;
    for (int i = 0; i < NI; i++) dat[i] = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d reset tx", i), 32'(txl[i]), 32'd1);
      chk($sformatf("u%0d reset ready", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("u%0d reset busy", i), 32'(busy[i]), 32'd0);
    end
    rst = '0;

    // 8N1, 0xA5
    offer(0, 8'hA5);
    push_frame(8'hA5, 0, 1);
    run_frame(0, 16, 10, 1'b0, 8'hA5, 0, 1'b1, t0);

    // valid held high: 0x00 then 0xFF back to back
    offer(0, 8'h00);
    push_frame(8'h00, 0, 1);
    push_frame(8'hFF, 0, 1);
    run_frame(0, 16, 10, 1'b1, 8'hFF, 0, 1'b1, t0);
    run_frame(0, 16, 10, 1'b0, 8'hFF, 0, 1'b1, t1);
    chk("u0 start-to-start spacing", 32'(t1 - t0), 32'd161);

    // even, then odd parity on 0x07
    offer(1, 8'h07);
    push_frame(8'h07, 2, 1);
    run_frame(1, 16, 11, 1'b0, 8'h07, 0, 1'b1, t0);
    offer(2, 8'h07);
    push_frame(8'h07, 1, 1);
    run_frame(2, 16, 11, 1'b0, 8'h07, 0, 1'b1, t0);

    // two stop bits
    offer(3, 8'h3C);
    push_frame(8'h3C, 0, 2);
    run_frame(3, 16, 11, 1'b0, 8'h3C, 0, 1'b1, t0);

    // reset 50 cycles into a frame; the truncated byte has no expected bits
    offer(0, 8'hC3);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (49) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("u0 tx after mid-frame reset", 32'(txl[0]), 32'd1);
    chk("u0 ready after mid-frame reset", 32'(rdy[0]), 32'd1);
    chk("u0 busy after mid-frame reset", 32'(busy[0]), 32'd0);
    rst[0] = 1'b0;

    // reset together with valid: nothing accepted, nothing queued
    @(negedge clk);
    rst[0] = 1'b1;
    vld[0] = 1'b1;
    dat[0] = 8'h77;
    @(negedge clk);
    chk("u0 busy after reset+valid", 32'(busy[0]), 32'd0);
    chk("u0 tx after reset+valid", 32'(txl[0]), 32'd1);
    rst[0] = 1'b0;
    vld[0] = 1'b0;
    @(negedge clk);
    chk("u0 busy one cycle later", 32'(busy[0]), 32'd0);

    offer(0, 8'h5A);
    push_frame(8'h5A, 0, 1);
    run_frame(0, 16, 10, 1'b0, 8'h5A, 0, 1'b1, t0);

    // full-rate frame with a stray valid pulse and data change mid-frame
    offer(4, 8'h55);
    push_frame(8'h55, 0, 1);
    run_frame(4, 5000, 10, 1'b0, 8'h55, 12000, 1'b0, t0);
    @(negedge clk);
    chk("u4 stray pulse not queued", 32'(busy[4]), 32'd0);
    chk("u4 scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
